ps2_input_port: RTL and testbench

Port-mapped PS/2 keyboard input peripheral for the PicoBlaze (kcpsm3) I/O bus: the read-side companion to the write-only display path. It receives PS/2 device-to-host frames and queues received bytes in a small FIFO. The CPU reads the bytes and a status register through `INPUT` instructions. It decodes its ports from `port_id`, drives `in_port` through a registered mux, and pops on `read_strobe`.

---
 rtl/ps2_input_port.sv | 184 ++++++++++++++++++
 tb/tb_ps2_input_port.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ps2_input_port.sv
// PS/2 device-to-host receiver with a byte FIFO, read by a kcpsm3 CPU
// through INPUT instructions (status port and data port).
module ps2_input_port #(
    parameter logic [7:0] STATUS_PORT     = 8'h81,
    parameter logic [7:0] DATA_PORT       = 8'h82,
    parameter int         FIFO_DEPTH_LOG2 = 3,
    parameter int         TIMEOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic [7:0] cpuPortId,
    input  logic       cpuReadStrobe,
    output logic [7:0] cpuReadData
);

    // state    | meaning
    // S_IDLE   | waiting for a start bit (falling edge with data low)
    // S_RECV   | shifting in 8 data bits, LSB first
    // S_PARITY | capturing the odd-parity bit
    // S_STOP   | checking the stop bit, pushing the byte if the frame is good
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_PARITY, S_STOP} state_t;

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    logic              clk_s1_q, clk_s2_q, clk_prev_q;
    logic              dat_s1_q, dat_s2_q;
    logic              fall;
    logic              bit_in;

    state_t            state_q;
    logic [3:0]        bitcnt_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic [TW-1:0]     tmo_q;
    logic              tmo_expire;
    logic              frame_ok;
    logic              push;
    logic              ferr_set;

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic                       full, not_empty;
    logic                       pop, push_ok, ovf_set, stat_clr;
    logic                       ovf_q, ferr_q;
    logic [7:0]                 status;
    logic [7:0]                 rd_data_d, rd_data_q;

    // Two-flop synchronizers; the extra clock flop gives the previous value for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2Clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2Data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall   = clk_prev_q & ~clk_s2_q;
    assign bit_in = dat_s2_q;

    // A falling edge reloads the timeout, so expiry only fires on a genuinely idle line.
    assign tmo_expire = (state_q != S_IDLE) && !fall && (tmo_q == TW'(1));
    assign frame_ok   = bit_in & (^{shift_q, parity_q});
    assign push       = (state_q == S_STOP) && fall && frame_ok;
    assign ferr_set   = ((state_q == S_STOP) && fall && !frame_ok) || tmo_expire;

    // Frame receiver FSM with its bit counter and inactivity timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 4'd0;
            shift_q  <= 8'h00;
            parity_q <= 1'b0;
            tmo_q    <= '0;
        end else if (tmo_expire) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                tmo_q <= fall && !bit_in ? TW'(TIMEOUT_CYCLES) : '0;
            end else begin
                tmo_q <= fall ? TW'(TIMEOUT_CYCLES) : tmo_q - TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (fall && !bit_in) begin
                        state_q  <= S_RECV;
                        bitcnt_q <= 4'd0;
                    end
                end
                S_RECV: begin
                    if (fall) begin
                        shift_q  <= {bit_in, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fall) begin
                        parity_q <= bit_in;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = cpuReadStrobe && (cpuPortId == DATA_PORT) && not_empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
    assign push_ok   = push && (!full || pop);
    assign ovf_set   = push && !push_ok;
    assign stat_clr  = cpuReadStrobe && (cpuPortId == STATUS_PORT);

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= shift_q;
    end

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and sticky error bits (a set beats a clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_set  ? 1'b1 : (stat_clr ? 1'b0 : ovf_q);
            ferr_q  <= ferr_set ? 1'b1 : (stat_clr ? 1'b0 : ferr_q);
        end
    end

    assign status = {4'(count_q), ferr_q, ovf_q, full, not_empty};

    // Read mux selection for the next registered in_port value.
    always_comb begin
        rd_data_d = 8'h00;
        if (cpuPortId == STATUS_PORT) begin
            rd_data_d = status;
        end else if (cpuPortId == DATA_PORT && not_empty) begin
            rd_data_d = mem_q[rptr_q];
        end
    end

    // Registered in_port so data is stable for the whole strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= 8'h00;
        else        rd_data_q <= rd_data_d;
    end

    assign cpuReadData = rd_data_q;

endmodule

// File: tb/tb_ps2_input_port.sv
// Directed bench for ps2_input_port: PS/2 frames in, kcpsm3-style INPUT reads out.
module tb_ps2_input_port;

    localparam int TMO = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] cpuPortId = 8'h00;
    logic       cpuReadStrobe = 1'b0;
    logic [7:0] cpuReadData;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rd;

    ps2_input_port #(
        .STATUS_PORT    (8'h81),
        .DATA_PORT      (8'h82),
        .FIFO_DEPTH_LOG2(3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2Clk       (ps2Clk),
        .ps2Data      (ps2Data),
        .cpuPortId    (cpuPortId),
        .cpuReadStrobe(cpuReadStrobe),
        .cpuReadData  (cpuReadData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // INPUT instruction: port id for two cycles, strobe in the second, sample there.
    task automatic cpu_read(input logic [7:0] port, output logic [7:0] data);
        @(negedge clk);
        cpuPortId     = port;
        cpuReadStrobe = 1'b0;
        @(negedge clk);
        cpuReadStrobe = 1'b1;
        data          = cpuReadData;
        @(negedge clk);
        cpuReadStrobe = 1'b0;
        cpuPortId     = 8'h00;
    endtask

    task automatic ps2_bit(input logic b);
        repeat (4) @(negedge clk);
        ps2Data = b;
        repeat (4) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_parity);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i]);
        ps2_bit((~^data) ^ bad_parity);
        ps2_bit(1'b1);
        repeat (6) @(negedge clk);
        ps2Data = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_rdata", cpuReadData, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        cpu_read(8'h81, rd); check("rst_status", rd, 8'h00);
        cpu_read(8'h82, rd); check("rst_data_empty", rd, 8'h00);
        cpu_read(8'h81, rd); check("rst_status_again", rd, 8'h00);

        // single good frame, 0x1C has three ones so parity bit is 0
        send_frame(8'h1C, 1'b0);
        cpu_read(8'h81, rd); check("good_status", rd, 8'h11);
        cpu_read(8'h82, rd); check("good_data", rd, 8'h1C);
        cpu_read(8'h81, rd); check("good_status_empty", rd, 8'h00);

        // bad parity: frameError only, nothing queued, cleared by status read
        send_frame(8'h1C, 1'b1);
        cpu_read(8'h81, rd); check("badpar_status", rd, 8'h08);
        cpu_read(8'h81, rd); check("badpar_cleared", rd, 8'h00);

        // nine frames into an 8-deep FIFO: count 8, full, overflow, notEmpty
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        cpu_read(8'h81, rd); check("ovf_status", rd, 8'h87);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(8'h82, rd); check($sformatf("ovf_data%0d", i), rd, 8'(i));
        end
        cpu_read(8'h81, rd); check("ovf_drained", rd, 8'h00);

        // partial frame then idle line: timeout abandons it
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TMO + 5) @(negedge clk);
        cpu_read(8'h81, rd); check("tmo_status", rd, 8'h08);
        send_frame(8'hAA, 1'b0);
        cpu_read(8'h81, rd); check("tmo_next_status", rd, 8'h11);
        cpu_read(8'h82, rd); check("tmo_next_data", rd, 8'hAA);

        // full FIFO, stop-bit push lands on the same edge as a data pop
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0);
        cpu_read(8'h81, rd); check("full_status", rd, 8'h83);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(i == 5);       // 0x20
        ps2_bit(1'b0);                                       // one '1' bit, parity 0
        repeat (4) @(negedge clk);
        ps2Data = 1'b1;
        repeat (4) @(negedge clk);
        ps2Clk = 1'b0;                 // raw fall; push happens on the 3rd rising edge after this
        @(negedge clk);
        cpuPortId = 8'h82;
        @(negedge clk);
        cpuReadStrobe = 1'b1;
        rd = cpuReadData;
        @(negedge clk);
        cpuReadStrobe = 1'b0;
        cpuPortId = 8'h00;
        check("coinc_pop_head", rd, 8'h10);
        repeat (6) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (4) @(negedge clk);
        cpu_read(8'h81, rd); check("coinc_status", rd, 8'h83);
        for (int i = 1; i < 8; i++) begin
            cpu_read(8'h82, rd); check($sformatf("coinc_data%0d", i), rd, 8'h10 + 8'(i));
        end
        cpu_read(8'h82, rd); check("coinc_last", rd, 8'h20);
        cpu_read(8'h81, rd); check("coinc_empty", rd, 8'h00);

        // reset mid-frame discards the partial byte
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        cpu_read(8'h81, rd); check("midrst_status", rd, 8'h00);
        send_frame(8'h5A, 1'b0);
        cpu_read(8'h81, rd); check("midrst_next_status", rd, 8'h11);
        cpu_read(8'h82, rd); check("midrst_next_data", rd, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
